seq_mem_readback: RTL and testbench

//  On-chip DEPTH x DATA_W memory with word and single-bit write ports plus a readback engine.
//  On start, the engine scans an address range through one synchronous read port.

---
 rtl/seq_mem_readback_pkg.sv | 18 +
 rtl/seq_mem_readback_buf.sv | 53 +++++
 rtl/seq_mem_readback.sv | 132 +++++++++++++
 tb/tb_seq_mem_readback.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mem_readback_pkg.sv
// Shared types for the memory readback engine: FSM states and the {addr,data} stream beat.
package seq_mem_readback_pkg;

  localparam int unsigned RB_DATA_W = 8;
  localparam int unsigned RB_ADDR_W = 4;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_RUN,
    RB_DRAIN
  } rb_state_e;

  typedef struct packed {
    logic [RB_ADDR_W-1:0] addr;
    logic [RB_DATA_W-1:0] data;
  } rb_beat_t;

endpackage

// File: rtl/seq_mem_readback_buf.sv
// Two-entry valid/ready output FIFO for readback beats; head entry drives the stream.
module seq_mem_readback_buf
  import seq_mem_readback_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  rb_beat_t   in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output rb_beat_t   out_beat,
  output logic [1:0] count
);

  rb_beat_t slot0;
  rb_beat_t slot1;
  logic     pop;

  assign out_valid = (count != 2'd0);
  assign out_beat  = slot0;
  assign pop       = out_valid & out_ready;

  // Pushes never arrive when full: the issuer reserves space before each read.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_beat;
          else               slot1 <= in_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= in_beat;
          end else begin
            slot0 <= slot1;
            slot1 <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_mem_readback.sv
// DEPTH x DATA_W memory with word/bit write ports and a range-scanning readback engine
// that emits {addr,data} beats on a valid/ready stream.
module seq_mem_readback
  import seq_mem_readback_pkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned ADDR_W = RB_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      bit_en,
  input  logic [ADDR_W-1:0]         bit_addr,
  input  logic [$clog2(DATA_W)-1:0] bit_index,
  input  logic                      bit_value,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         first_addr,
  input  logic [ADDR_W-1:0]         last_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_data
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  rb_state_e         state, state_d;
  logic [ADDR_W-1:0] cur, cur_d;
  logic [ADDR_W-1:0] rem, rem_d;
  logic              done_d;
  logic              issue;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  rb_beat_t          rd_beat;
  rb_beat_t          out_beat;
  logic [1:0]        buf_count;
  logic              pop;
  logic [2:0]        occ;

  // Bit write is ordered after the word write so it overrides that one bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (bit_en) mem[bit_addr][bit_index] <= bit_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_beat.addr <= rd_addr;
        rd_beat.data <= mem[rd_addr];
      end
    end
  end

  seq_mem_readback_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_valid),
    .in_beat   (rd_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (out_beat),
    .count     (buf_count)
  );

  assign out_addr = out_beat.addr;
  assign out_data = out_beat.data;
  assign busy     = (state != RB_IDLE);
  assign pop      = out_valid & out_ready;
  // Credit counts the slot freed by this cycle's pop so a steady stream has no bubbles.
  assign occ      = {1'b0, buf_count} + {2'b00, rd_valid} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RB_IDLE;
      cur   <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
      rem   <= rem_d;
      done  <= done_d;
    end
  end

  // The first read is issued in the start cycle itself, so rem counts the issues still owed.
  always_comb begin
    state_d = state;
    cur_d   = cur;
    rem_d   = rem;
    done_d  = 1'b0;
    issue   = 1'b0;
    rd_addr = cur;
    case (state)
      RB_IDLE: begin
        if (start) begin
          issue   = 1'b1;
          rd_addr = first_addr;
          cur_d   = first_addr + ADDR_W'(1);
          rem_d   = last_addr - first_addr;
          state_d = (last_addr == first_addr) ? RB_DRAIN : RB_RUN;
        end
      end
      RB_RUN: begin
        if (occ < 3'd2) begin
          issue = 1'b1;
          cur_d = cur + ADDR_W'(1);
          rem_d = rem - ADDR_W'(1);
          if (rem == ADDR_W'(1)) state_d = RB_DRAIN;
        end
      end
      RB_DRAIN: begin
        if (!rd_valid && (buf_count == 2'd0 || (buf_count == 2'd1 && pop))) begin
          state_d = RB_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = RB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_mem_readback.sv
// Scoreboard bench for seq_mem_readback: expected beats are queued from a memory model at start.
module tb_seq_mem_readback;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       bit_en;
  logic [3:0] bit_addr;
  logic [2:0] bit_index;
  logic       bit_value;
  logic       start;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic       busy;
  logic       done;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_addr;
  logic [7:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  logic [7:0]  mdl [16];
  logic [11:0] sb [$];

  seq_mem_readback #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .bit_en     (bit_en),
    .bit_addr   (bit_addr),
    .bit_index  (bit_index),
    .bit_value  (bit_value),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: every handshake pops the scoreboard; stalled beats must hold.
  logic        prev_stall = 1'b0;
  logic [11:0] prev_beat  = '0;
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid)
        check("hold", 32'({out_addr, out_data}), 32'(prev_beat));
      if (out_valid && out_ready) begin
        exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'h1000;
        check("beat", 32'({out_addr, out_data}), exp);
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_addr, out_data};
    end
  end

  function automatic logic rdy(input bit bp, input int n);
    int k;
    k = n - 2;
    if (!bp || k < 0) return 1'b1;
    if (k < 4) return (k % 2 == 0);
    if (k < 9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wr_word(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic scan(input logic [3:0] f, input logic [3:0] l, input bit bp, input bit mid,
                      input bit cowr, input logic [7:0] cod, output int n);
    logic [3:0] d;
    int len;
    d   = l - f;
    len = int'(d) + 1;
    for (int i = 0; i < len; i++) begin
      logic [3:0] a;
      a = f + 4'(i);
      sb.push_back({a, mdl[a]});
    end
    first_addr = f; last_addr = l; start = 1'b1; out_ready = rdy(bp, 0);
    if (cowr) begin
      wr_en = 1'b1; wr_addr = f; wr_data = cod;
      mdl[f] = cod;
    end
    tick();
    n = 1;
    start = 1'b0; wr_en = 1'b0; out_ready = rdy(bp, 1);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
    while (!done && n < 300) begin
      tick();
      n++;
      out_ready = rdy(bp, n);
      if (n == 2) check("lat_n2_valid", 32'(out_valid), 32'd1);
      if (mid && n == 5) begin start = 1'b1; first_addr = 4'd3; last_addr = 4'd3; end
      if (mid && n == 6) start = 1'b0;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bit_en = 1'b0; bit_addr = '0; bit_index = '0; bit_value = 1'b0;
    start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) wr_word(4'(i), 8'(3 * i + 1));

    // 1: basic range with exact latency
    scan(4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 8'h00, cyc);
    check("t1_done_cycle", 32'(cyc), 32'd6);

    // 2: wrap, single beat, full depth
    scan(4'd14, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00, cyc);
    check("t2_wrap_done_cycle", 32'(cyc), 32'd6);
    scan(4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 8'h00, cyc);
    check("t2_one_done_cycle", 32'(cyc), 32'd3);
    scan(4'd6, 4'd5, 1'b0, 1'b0, 1'b0, 8'h00, cyc);
    check("t2_full_done_cycle", 32'(cyc), 32'd18);

    // 3: backpressure over a full scan
    scan(4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 8'h00, cyc);

    // 4: word and bit write to the same word in one cycle
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h0F;
    bit_en = 1'b1; bit_addr = 4'd3; bit_index = 3'd5; bit_value = 1'b1;
    tick();
    wr_en = 1'b0; bit_en = 1'b0;
    mdl[3] = 8'h2F;
    scan(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 8'h00, cyc);

    // 5: read-before-write, then start while busy
    wr_word(4'd4, 8'h55);
    scan(4'd4, 4'd4, 1'b0, 1'b0, 1'b1, 8'hAA, cyc);
    scan(4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 8'h00, cyc);
    scan(4'd8, 4'd7, 1'b0, 1'b1, 1'b0, 8'h00, cyc);
    check("t5_mid_start_done_cycle", 32'(cyc), 32'd18);

    // 6: reset mid-scan, then rescan retained memory
    for (int i = 0; i < 10; i++) sb.push_back({4'(i), mdl[i]});
    first_addr = 4'd0; last_addr = 4'd9; start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_beats_before_rst", 32'(sb.size()), 32'd8);
    sb.delete();
    out_ready = 1'b1;
    tick();
    check("t6_done_after", 32'(done), 32'd0);
    scan(4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 8'h00, cyc);
    check("t6_rescan_done_cycle", 32'(cyc), 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
